// File: rtl/ika87ad_irqarb.sv
// ika87ad_irqarb
// Interrupt arbiter between the per-source interrupt flag registers and the
// CPU sequencer. It picks the highest-priority pending source and raises a
// held request that carries that source's vector and code. When the CPU
// accepts the request, the arbiter returns the code to the flag registers
// together with an auto-ack strobe.
//
// Ports
//   i_EMUCLK    system clock; all state updates on posedge
//   i_MRST      synchronous active-high reset
//   i_TICK      CPU cycle enable for arbitration, withdrawal and release
//   i_IFLAG     flag outputs; bit n is source code n+1
//   i_MASK      1 = source masked; same bit order as i_IFLAG
//   i_EI        CPU interrupt-enable flag (maskable sources only)
//   i_NMI_DET   one-cycle NMI edge pulse
//   i_IRQ_ACK   one-cycle CPU acceptance pulse
//   o_IRQ_REQ   held request to the CPU
//   o_VECTOR    vector of the latched winner
//   o_IRQ_CODE  code of the latched winner (0 = NMI, 1..10 maskable)
//   o_ACK_CODE  code returned to the flag registers
//   o_AUTO_ACK  auto-ack strobe to the flag registers
//   o_MULTI_EN  per pair: both members unmasked (combinational)
module ika87ad_irqarb #(
  parameter logic [15:0] NMI_VECTOR  = 16'h0004,
  parameter logic [15:0] BASE_VECTOR = 16'h0008
) (
  input  logic        i_EMUCLK,
  input  logic        i_MRST,
  input  logic        i_TICK,
  input  logic [9:0]  i_IFLAG,
  input  logic [9:0]  i_MASK,
  input  logic        i_EI,
  input  logic        i_NMI_DET,
  input  logic        i_IRQ_ACK,
  output logic        o_IRQ_REQ,
  output logic [15:0] o_VECTOR,
  output logic [4:0]  o_IRQ_CODE,
  output logic [4:0]  o_ACK_CODE,
  output logic        o_AUTO_ACK,
  output logic [4:0]  o_MULTI_EN
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_nmi_pend;
  logic        r_req;
  logic [15:0] r_vector;
  logic [4:0]  r_code;
  logic [4:0]  r_ack_code;
  logic        r_auto_ack;

  logic [9:0]  w_elig;
  logic [4:0]  w_win;
  logic        w_any;
  logic        w_still;

  // Pairs share a vector: group g = (code-1)/2, spaced 8 bytes apart.
  function automatic logic [15:0] f_vector(input logic [4:0] code);
    logic [4:0] grp;
    grp = (code - 5'd1) >> 1;
    if (code == 5'd0) f_vector = NMI_VECTOR;
    else              f_vector = BASE_VECTOR + {8'd0, grp, 3'd0};
  endfunction

  // NMI first, then lowest code; scanning from the top lets the lowest
  // set bit overwrite any higher one.
  function automatic logic [4:0] f_winner(input logic nmi, input logic [9:0] e);
    f_winner = 5'd0;
    if (!nmi) begin
      for (int i = 9; i >= 0; i--) begin
        if (e[i]) f_winner = 5'(i + 1);
      end
    end
  endfunction

  assign w_elig = i_EI ? (i_IFLAG & ~i_MASK) : 10'd0;
  assign w_any  = r_nmi_pend | (|w_elig);
  assign w_win  = f_winner(r_nmi_pend, w_elig);

  // Whether the latched maskable winner is still eligible.
  always_comb begin
    w_still = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (r_code == 5'(i + 1)) w_still = w_elig[i];
    end
  end

  always_comb begin
    o_MULTI_EN = 5'd0;
    for (int g = 0; g < 5; g++) begin
      o_MULTI_EN[g] = ~i_MASK[2*g] & ~i_MASK[2*g+1];
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      r_state    <= ST_IDLE;
      r_nmi_pend <= 1'b0;
      r_req      <= 1'b0;
      r_vector   <= 16'd0;
      r_code     <= 5'd0;
      r_ack_code <= 5'd0;
      r_auto_ack <= 1'b0;
    end else begin
      // A new NMI edge on the clearing cycle keeps the NMI pending.
      if (i_NMI_DET)
        r_nmi_pend <= 1'b1;
      else if (r_state == ST_REQ && i_IRQ_ACK && r_code == 5'd0)
        r_nmi_pend <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_TICK && w_any) begin
            r_req    <= 1'b1;
            r_code   <= w_win;
            r_vector <= f_vector(w_win);
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack is sampled every clock; withdrawal only on a tick, and ack wins.
          if (i_IRQ_ACK) begin
            r_req      <= 1'b0;
            r_ack_code <= r_code;
            r_auto_ack <= 1'b1;
            r_state    <= ST_SERV;
          end else if (i_TICK && r_code != 5'd0 && !w_still) begin
            r_req   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SERV: begin
          // Strobe stays up until the flag registers' next tick.
          if (i_TICK) begin
            r_auto_ack <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_IRQ_REQ  = r_req;
  assign o_VECTOR   = r_vector;
  assign o_IRQ_CODE = r_code;
  assign o_ACK_CODE = r_ack_code;
  assign o_AUTO_ACK = r_auto_ack;

endmodule
